// File: rtl/vehicle_request.sv
// -----------------------------------------------------------------------------
// vehicle_request
// Conditions the raw side-road vehicle-loop sensor into a service request for
// the side-road controller. The sensor is synchronised, debounced and
// edge-detected. Each arrival is latched as a request that is held until the
// controller leaves its idle state (3'b000). One further arrival during
// service is queued. A sensor that stays high too long is flagged as stuck
// and suppressed until it has been seen low again.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   sensor  in   raw loop sensor, asynchronous to clk, active high
//   q       in   [2:0] controller state feedback, 3'b000 = idle/main-green
//   en      out  registered service request (high while a request is pending)
//   queued  out  registered, high while an arrival waits behind service
//   fault   out  registered stuck-sensor indication
// -----------------------------------------------------------------------------
module vehicle_request #(
  parameter int DEB_W   = 16,
  parameter int DEB_CNT = 1000,
  parameter int STK_W   = 20,
  parameter int STK_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic [2:0] q,
  output logic       en,
  output logic       queued,
  output logic       fault
);

  // The DEB_CNT-th disagreeing sample is the one seen with DEB_CNT-1 already
  // counted, so the counter never needs to hold DEB_CNT itself.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STK_CNT);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);
  localparam logic [STK_W-1:0] STK_ZERO = STK_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PEND  = 3'd1,
    ST_SERV  = 3'd2,
    ST_SERVQ = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic             filt_dly_q;
  logic [DEB_W-1:0] dcnt_q;
  logic [DEB_W-1:0] dcnt_d;
  logic [STK_W-1:0] scnt_q;
  logic [STK_W-1:0] scnt_d;
  logic [2:0]       q_prev_q;
  state_e           state_q;
  state_e           state_d;
  logic             en_q;
  logic             queued_q;
  logic             fault_q;

  logic             rise_s;
  logic             start_s;
  logic             done_s;
  logic             stuck_s;

  // Two-flop synchroniser for the asynchronous sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples, adopt the new level on the
  // DEB_CNT-th one; any agreeing sample restarts the count.
  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    if (sync2_q == filt_q) begin
      dcnt_d = DEB_ZERO;
    end else if (dcnt_q >= DEB_LAST) begin
      filt_d = sync2_q;
      dcnt_d = DEB_ZERO;
    end else begin
      dcnt_d = dcnt_q + DEB_ONE;
    end
  end

  // Stuck counter: time spent with the filtered level high, saturating.
  always_comb begin
    scnt_d = scnt_q;
    if (!filt_q) begin
      scnt_d = STK_ZERO;
    end else if (scnt_q >= STK_MAX) begin
      scnt_d = STK_MAX;
    end else begin
      scnt_d = scnt_q + STK_ONE;
    end
  end

  // Filter, edge-detect, stuck and controller-feedback history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b0;
      dcnt_q     <= DEB_ZERO;
      filt_dly_q <= 1'b0;
      scnt_q     <= STK_ZERO;
      q_prev_q   <= 3'b000;
    end else begin
      filt_q     <= filt_d;
      dcnt_q     <= dcnt_d;
      filt_dly_q <= filt_q;
      scnt_q     <= scnt_d;
      q_prev_q   <= q;
    end
  end

  assign rise_s  = filt_q & ~filt_dly_q;
  assign start_s = (q_prev_q == 3'b000) & (q != 3'b000);
  assign done_s  = (q_prev_q != 3'b000) & (q == 3'b000);
  assign stuck_s = (scnt_q == STK_MAX);

  // Request FSM next state; a stuck sensor overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (stuck_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_FAULT: begin
          if (!filt_q) state_d = ST_IDLE;
          else         state_d = ST_FAULT;
        end
        ST_IDLE: begin
          // Controller activity is irrelevant here; only an arrival matters.
          if (rise_s) state_d = ST_PEND;
          else        state_d = ST_IDLE;
        end
        ST_PEND: begin
          // A second arrival while pending merges into the same request.
          if (start_s && rise_s) state_d = ST_SERVQ;
          else if (start_s)      state_d = ST_SERV;
          else                   state_d = ST_PEND;
        end
        ST_SERV: begin
          if (done_s && rise_s) state_d = ST_PEND;
          else if (done_s)      state_d = ST_IDLE;
          else if (rise_s)      state_d = ST_SERVQ;
          else                  state_d = ST_SERV;
        end
        ST_SERVQ: begin
          if (done_s) state_d = ST_PEND;
          else        state_d = ST_SERVQ;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state, so each output
  // changes on the same edge as the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      queued_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= (state_d == ST_PEND);
      queued_q <= (state_d == ST_SERVQ);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign en     = en_q;
  assign queued = queued_q;
  assign fault  = fault_q;

  vehicle_request_chk #(
    .DEB_W  (DEB_W),
    .DEB_CNT(DEB_CNT),
    .STK_W  (STK_W),
    .STK_CNT(STK_CNT)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .queued(queued_q),
    .fault (fault_q),
    .dcnt  (dcnt_q),
    .scnt  (scnt_q)
  );

endmodule

// -----------------------------------------------------------------------------
// vehicle_request_chk
// Structural invariants of vehicle_request: outputs mutually exclusive and
// both counters inside their working ranges.
// Ports: clk, rst_n, the three registered outputs, dcnt and scnt.
// -----------------------------------------------------------------------------
module vehicle_request_chk #(
  parameter int DEB_W   = 16,
  parameter int DEB_CNT = 1000,
  parameter int STK_W   = 20,
  parameter int STK_CNT = 500000
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  input logic             queued,
  input logic             fault,
  input logic [DEB_W-1:0] dcnt,
  input logic [STK_W-1:0] scnt
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STK_CNT);

  a_outputs_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0({en, queued, fault})
  );

  a_dcnt_range: assert property (
    @(posedge clk) disable iff (!rst_n) (dcnt <= DEB_LAST)
  );

  a_scnt_range: assert property (
    @(posedge clk) disable iff (!rst_n) (scnt <= STK_MAX)
  );

endmodule

// File: tb/tb_vehicle_request.sv
module tb_vehicle_request;

  localparam int DEB_W   = 16;
  localparam int DEB_CNT = 4;
  localparam int STK_W   = 20;
  localparam int STK_CNT = 64;

  logic       clk;
  logic       rst_n;
  logic       sensor;
  logic [2:0] q;
  logic       en;
  logic       queued;
  logic       fault;

  int n_vec;
  int n_miss;

  vehicle_request #(
    .DEB_W  (DEB_W),
    .DEB_CNT(DEB_CNT),
    .STK_W  (STK_W),
    .STK_CNT(STK_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sensor(sensor),
    .q     (q),
    .en    (en),
    .queued(queued),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: sensor history, run length of disagreement with the
  // filtered level, time the filtered level has been high, and the request
  // status as independent flags.
  // ---------------------------------------------------------------------------
  bit m_hist[2];     // [0] = last raw sample, [1] = sample before that
  bit m_filt;
  bit m_filt_prev;
  int m_run;         // consecutive samples disagreeing with m_filt
  int m_high_time;   // cycles filtered level has been high, capped
  int m_qprev;
  bit m_pending;
  bit m_serving;
  bit m_queued;
  bit m_faulted;

  task automatic model_reset();
    m_hist[0] = 1'b0; m_hist[1] = 1'b0;
    m_filt = 1'b0; m_filt_prev = 1'b0;
    m_run = 0; m_high_time = 0; m_qprev = 0;
    m_pending = 1'b0; m_serving = 1'b0; m_queued = 1'b0; m_faulted = 1'b0;
  endtask

  task automatic model_step(input bit s_in, input int q_in);
    bit rise, start, done, stuck, old_filt;
    stuck = (m_high_time == STK_CNT);
    rise  = m_filt && !m_filt_prev;
    start = (m_qprev == 0) && (q_in != 0);
    done  = (m_qprev != 0) && (q_in == 0);
    if (stuck) begin
      m_faulted = 1'b1; m_pending = 1'b0; m_serving = 1'b0; m_queued = 1'b0;
    end else if (m_faulted) begin
      if (!m_filt) m_faulted = 1'b0;
    end else if (m_pending) begin
      if (start) begin
        m_pending = 1'b0; m_serving = 1'b1; m_queued = rise;
      end
    end else if (m_serving) begin
      if (m_queued) begin
        if (done) begin
          m_serving = 1'b0; m_queued = 1'b0; m_pending = 1'b1;
        end
      end else if (done) begin
        m_serving = 1'b0; m_pending = rise;
      end else if (rise) begin
        m_queued = 1'b1;
      end
    end else if (rise) begin
      m_pending = 1'b1;
    end
    old_filt = m_filt;
    if (m_hist[1] == m_filt) begin
      m_run = 0;
    end else if (m_run + 1 == DEB_CNT) begin
      m_filt = m_hist[1];
      m_run  = 0;
    end else begin
      m_run = m_run + 1;
    end
    m_filt_prev = old_filt;
    if (old_filt) m_high_time = (m_high_time + 1 > STK_CNT) ? STK_CNT : m_high_time + 1;
    else          m_high_time = 0;
    m_hist[1] = m_hist[0];
    m_hist[0] = s_in;
    m_qprev   = q_in;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model on the
  // rising edge, compare outputs at the next falling edge.
  task automatic cycle(input bit s_in, input logic [2:0] q_in);
    sensor = s_in;
    q      = q_in;
    @(posedge clk);
    model_step(s_in, int'(q_in));
    @(negedge clk);
    chk_eq("en",     32'(en),     32'(m_pending));
    chk_eq("queued", 32'(queued), 32'(m_queued));
    chk_eq("fault",  32'(fault),  32'(m_faulted));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_en",     32'(en),     32'd0);
    chk_eq("rst_queued", 32'(queued), 32'd0);
    chk_eq("rst_fault",  32'(fault),  32'd0);
    model_reset();
    sensor = 1'b0;
    q      = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s_hold, q_hold;
    bit s_val;
    logic [2:0] q_val;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b1;
    sensor = 1'b0;
    q      = 3'b000;
    @(negedge clk);
    do_reset();

    // 1: clean arrival, request appears at edge DEB_CNT+3 and holds.
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 3'b000);
      chk_eq("t1_lat", 32'(en), (i >= 7) ? 32'd1 : 32'd0);
    end

    // 2: service start drops en; service end does not re-request.
    cycle(1'b1, 3'b001);
    chk_eq("t2_fall", 32'(en), 32'd0);
    repeat (8) cycle(1'b0, 3'b001);
    cycle(1'b0, 3'b000);
    chk_eq("t2_done_en", 32'(en), 32'd0);
    chk_eq("t2_done_q",  32'(queued), 32'd0);
    repeat (4) cycle(1'b0, 3'b000);

    // 3: bounce shorter than the debounce window.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cycle(bit'((i / 2) % 2), 3'b000);
      chk_eq("t3_en",    32'(en),    32'd0);
      chk_eq("t3_fault", 32'(fault), 32'd0);
    end

    // 4: arrival during service is queued, then re-requested on done.
    do_reset();
    repeat (10) cycle(1'b1, 3'b000);
    repeat (10) cycle(1'b0, 3'b000);
    chk_eq("t4_req", 32'(en), 32'd1);
    cycle(1'b0, 3'b001);
    repeat (10) cycle(1'b1, 3'b001);
    repeat (4) cycle(1'b0, 3'b001);
    chk_eq("t4_queued", 32'(queued), 32'd1);
    chk_eq("t4_en_off", 32'(en),     32'd0);
    cycle(1'b0, 3'b000);
    chk_eq("t4_q_clr", 32'(queued), 32'd0);
    chk_eq("t4_en_on", 32'(en),     32'd1);

    // 5: stuck sensor raises fault, clears only after a clean low.
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, 3'b000);
      if (i == 7)  chk_eq("t5_en",    32'(en),    32'd1);
      if (i == 71) chk_eq("t5_fault", 32'(fault), 32'd1);
    end
    chk_eq("t5_en_off", 32'(en), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      cycle(1'b0, 3'b000);
      chk_eq("t5_en_low", 32'(en), 32'd0);
      if (j == 7) chk_eq("t5_hold", 32'(fault), 32'd1);
      if (j == 8) chk_eq("t5_exit", 32'(fault), 32'd0);
    end

    // 6: asynchronous reset in SERVQ drops everything.
    do_reset();
    repeat (10) cycle(1'b1, 3'b000);
    repeat (6)  cycle(1'b0, 3'b000);
    cycle(1'b0, 3'b001);
    repeat (10) cycle(1'b1, 3'b001);
    repeat (3)  cycle(1'b0, 3'b001);
    chk_eq("t6_servq", 32'(queued), 32'd1);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, (i < 10) ? 3'b001 : 3'b000);
      chk_eq("t6_idle", 32'(en), 32'd0);
    end

    // Randomised run: sensor runs of mixed length, controller state random.
    do_reset();
    s_val = 1'b0; s_hold = 0;
    q_val = 3'b000; q_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (s_hold == 0) begin
        s_val = ~s_val;
        if ($urandom_range(0, 24) == 0) s_hold = 90;
        else if ($urandom_range(0, 1) == 0) s_hold = int'($urandom_range(1, 5));
        else s_hold = int'($urandom_range(6, 16));
      end
      if (q_hold == 0) begin
        if ($urandom_range(0, 1) == 0) q_val = 3'b000;
        else q_val = 3'($urandom_range(1, 7));
        q_hold = int'($urandom_range(1, 20));
      end
      cycle(s_val, q_val);
      s_hold--;
      q_hold--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
